// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   XLEN / REG_AW / STALL_W : default data, register-number and stall-counter widths
//   REG_ZERO                : x0, writes to it never use the RF port
//   GNT_ALU / GNT_MEM       : round-robin grant encodings (also the requester index)
package rf_wb_arbiter_pkg;
    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int STALL_W = 16;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    localparam logic GNT_ALU = 1'b0;
    localparam logic GNT_MEM = 1'b1;
endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst    : clock, async active-high reset (last_grant -> GNT_MEM)
//   req[1:0]    : requests, index GNT_ALU / GNT_MEM
//   accept      : the granted request transferred this cycle
//   grant[1:0]  : one-hot grant (combinational)
// On a tie the requester that did not win last time is granted. last_grant
// resets to MEM so the first tie after reset goes to ALU.
module rr_arb2
    import rf_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == GNT_MEM) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= GNT_MEM;
        else if (accept)
            last_grant <= grant[GNT_MEM] ? GNT_MEM : GNT_ALU;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single RF write port between ALU and load-unit
// writeback requesters.
//   clk, rst                      : clock, async active-high reset
//   alu_valid/rd/data, alu_ready  : ALU writeback request / accept
//   mem_valid/rd/data, mem_ready  : load writeback request / accept
//   rf_rd, rf_wdata               : registered RF write port (rf_rd==0 => no write)
//   pend_valid                    : output stage holds a real write (bypass source)
//   stall_cnt                     : saturating count of cycles a requester was held off
// Requests to x0 are acknowledged immediately without touching the port or
// the round-robin state; nonzero requests go through rr_arb2.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int XLEN    = rf_wb_arbiter_pkg::XLEN,
    parameter int REG_AW  = rf_wb_arbiter_pkg::REG_AW,
    parameter int STALL_W = rf_wb_arbiter_pkg::STALL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_valid,
    input  logic [REG_AW-1:0]  alu_rd,
    input  logic [XLEN-1:0]    alu_data,
    output logic               alu_ready,
    input  logic               mem_valid,
    input  logic [REG_AW-1:0]  mem_rd,
    input  logic [XLEN-1:0]    mem_data,
    output logic               mem_ready,
    output logic [REG_AW-1:0]  rf_rd,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               pend_valid,
    output logic [STALL_W-1:0] stall_cnt
);
    logic       alu_zero, mem_zero;
    logic [1:0] req, grant;
    logic       stall;

    assign alu_zero = (alu_rd == REG_AW'(REG_ZERO));
    assign mem_zero = (mem_rd == REG_AW'(REG_ZERO));

    // Only nonzero destinations compete for the port.
    assign req[GNT_ALU] = alu_valid & ~alu_zero & ~rst;
    assign req[GNT_MEM] = mem_valid & ~mem_zero & ~rst;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (|grant),   // a grant implies valid, so it always transfers
        .grant  (grant)
    );

    assign alu_ready = ~rst & alu_valid & (alu_zero | grant[GNT_ALU]);
    assign mem_ready = ~rst & mem_valid & (mem_zero | grant[GNT_MEM]);

    // Output stage: rf_wdata holds when idle, only rf_rd marks the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (grant[GNT_ALU]) begin
            rf_rd    <= alu_rd;
            rf_wdata <= alu_data;
        end else if (grant[GNT_MEM]) begin
            rf_rd    <= mem_rd;
            rf_wdata <= mem_data;
        end else begin
            rf_rd    <= '0;
        end
    end

    assign pend_valid = (rf_rd != '0);

    assign stall = (alu_valid & ~alu_ready) | (mem_valid & ~mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_rd = '0, mem_rd = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready, pend_valid;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;
    wr_t sb[$];

    logic [31:0] regs [32];

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_rd(rf_rd), .rf_wdata(rf_wdata), .pend_valid(pend_valid), .stall_cnt(stall_cnt)
    );

    // Register file model fed by the DUT write port.
    always @(posedge clk)
        if (rf_rd != 5'd0) regs[rf_rd] <= rf_wdata;

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
    endtask

    // One cycle: check readies, push the expected port write, clock, pop and compare.
    task automatic step(input string nm, input logic ear, input logic emr);
        wr_t e, g;
        #1;
        checks++;
        if (alu_ready !== ear) begin errors++; $display("FAIL %s alu_ready got %b exp %b", nm, alu_ready, ear); end
        checks++;
        if (mem_ready !== emr) begin errors++; $display("FAIL %s mem_ready got %b exp %b", nm, mem_ready, emr); end
        e.rd = 5'd0; e.data = '0;
        if (ear && alu_valid && alu_rd != 5'd0) begin e.rd = alu_rd; e.data = alu_data; end
        else if (emr && mem_valid && mem_rd != 5'd0) begin e.rd = mem_rd; e.data = mem_data; end
        sb.push_back(e);
        @(posedge clk); #1;
        g = sb.pop_front();
        checks++;
        if (rf_rd !== g.rd) begin errors++; $display("FAIL %s rf_rd got %0d exp %0d", nm, rf_rd, g.rd); end
        checks++;
        if (pend_valid !== (g.rd != 5'd0)) begin errors++; $display("FAIL %s pend_valid got %b exp %b", nm, pend_valid, g.rd != 5'd0); end
        if (g.rd != 5'd0) begin
            checks++;
            if (rf_wdata !== g.data) begin errors++; $display("FAIL %s rf_wdata got %h exp %h", nm, rf_wdata, g.data); end
        end
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 5'd4, 32'h1234, 1, 5'd6, 32'h5678);
        rst = 1'b1;
        #1;
        checks++;
        if ({rf_rd, rf_wdata, alu_ready, mem_ready, stall_cnt, pend_valid} !== '0) begin
            errors++;
            $display("FAIL reset rf_rd=%0d rf_wdata=%h ar=%b mr=%b stall=%0d pend=%b exp all 0",
                     rf_rd, rf_wdata, alu_ready, mem_ready, stall_cnt, pend_valid);
        end
        do_reset();
    endtask

    task automatic test_single();
        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        step("single", 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        step("single_idle", 0, 0);
        checks++;
        if (regs[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL rf_x5 got %h exp deadbeef", regs[5]); end
    endtask

    task automatic test_rr();
        do_reset();
        drive(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2);
        for (int i = 0; i < 6; i++)
            step("rr", (i % 2) == 0, (i % 2) == 1);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (stall_cnt !== 16'd6) begin errors++; $display("FAIL rr_stall got %0d exp 6", stall_cnt); end
    endtask

    task automatic test_x0();
        // last_grant is MEM here, so this tie goes to ALU
        drive(1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
        step("x0_tie1", 1, 0);
        // x0 request must not move last_grant to MEM
        drive(0, 0, 0, 1, 5'd0, 32'h99);
        step("x0_mem_zero", 0, 1);
        drive(1, 5'd1, 32'h33, 1, 5'd2, 32'h44);
        step("x0_tie2", 0, 1);
        // ALU x0 and MEM nonzero both accepted, MEM owns the port
        drive(1, 5'd0, 32'h55, 1, 5'd3, 32'h7);
        step("x0_both", 1, 1);
        drive(1, 5'd1, 32'h66, 1, 5'd2, 32'h77);
        step("x0_tie3", 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        step("x0_idle", 0, 0);
        checks++;
        if (regs[0] === 32'h99 || regs[0] === 32'h55) begin errors++; $display("FAIL x0_write got %h exp untouched", regs[0]); end
    endtask

    task automatic test_async_reset();
        regs[9] = 32'hCAFE0009;
        drive(1, 5'd9, 32'h0BAD0009, 0, 0, 0);
        step("ar_load", 1, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rf_rd !== 5'd0 || pend_valid !== 1'b0) begin
            errors++; $display("FAIL async_rst rf_rd=%0d pend=%b exp 0/0", rf_rd, pend_valid);
        end
        checks++;
        if (alu_ready !== 1'b0) begin errors++; $display("FAIL async_rst_ready got %b exp 0", alu_ready); end
        @(posedge clk); #1;
        checks++;
        if (regs[9] !== 32'hCAFE0009) begin errors++; $display("FAIL x9_dropped got %h exp cafe0009", regs[9]); end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step("ar_idle", 0, 0);
    endtask

    task automatic test_stall_sat();
        do_reset();
        drive(1, 5'd7, 32'h1, 1, 5'd8, 32'h2);
        for (int i = 0; i < 100; i++) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'd100) begin errors++; $display("FAIL stall_100 got %0d exp 100", stall_cnt); end
        for (int i = 0; i < 66000; i++) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat got %h exp ffff", stall_cnt); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        test_reset();
        test_single();
        test_rr();
        test_x0();
        test_async_reset();
        test_stall_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
